// File: rtl/regfile_2r1w_sweep.sv
// Parametrised 2-read/1-write register file with a hardware clear-sweep and a write-error pulse.
// Optional write-through forwarding on both read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w_sweep #(
   parameter int            N         = 8,
   parameter int            AW        = 3,
   parameter logic [N-1:0]  RESET_VAL = '0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          WrEn,
   input  logic [AW-1:0] WA,
   input  logic [N-1:0]  Din,
   input  logic [AW-1:0] RA,
   input  logic [AW-1:0] RB,
   input  logic          CLR,
   output logic [N-1:0]  DoutA,
   output logic [N-1:0]  DoutB,
   output logic          BUSY,
   output logic          WERR,
   output logic          o_dbg_state
);

   localparam int            DEPTH    = 1 << AW;
   localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SWEEP = 1'b1
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_cnt;
   logic [N-1:0]  r_mem [DEPTH];
   logic [N-1:0]  r_dout_a;
   logic [N-1:0]  r_dout_b;
   logic          r_busy;
   logic          r_werr;

   logic          w_wr_ok;
   logic          w_drop;
   logic          w_fwd_a;
   logic          w_fwd_b;

   // A write is only accepted in IDLE without a competing CLR; every other WrEn is dropped.
   always_comb begin
      w_wr_ok = 1'b0;
      w_drop  = 1'b0;
      if (r_state == S_IDLE) begin
         w_wr_ok = WrEn & ~CLR;
         w_drop  = WrEn & CLR;
      end else begin
         w_drop  = WrEn;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign w_fwd_a = w_wr_ok && (WA == RA);
   assign w_fwd_b = w_wr_ok && (WA == RB);
`else
   assign w_fwd_a = 1'b0;
   assign w_fwd_b = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= RESET_VAL;
         end
         r_dout_a <= '0;
         r_dout_b <= '0;
         r_busy   <= 1'b0;
         r_werr   <= 1'b0;
         r_cnt    <= '0;
         r_state  <= S_IDLE;
      end else begin
         // Sweep writes are never forwarded; reads see pre-edge storage.
         r_dout_a <= w_fwd_a ? Din : r_mem[RA];
         r_dout_b <= w_fwd_b ? Din : r_mem[RB];
         r_werr   <= w_drop;
         if (w_wr_ok) begin
            r_mem[WA] <= Din;
         end
         case (r_state)
            S_IDLE: begin
               if (CLR) begin
                  r_state <= S_SWEEP;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_SWEEP: begin
               r_mem[r_cnt] <= RESET_VAL;
               r_cnt        <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign DoutA       = r_dout_a;
   assign DoutB       = r_dout_b;
   assign BUSY        = r_busy;
   assign WERR        = r_werr;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_regfile_2r1w_sweep.sv
// Directed and randomized bench for regfile_2r1w_sweep against an array-based reference model.
module tb_regfile_2r1w_sweep;

   localparam int N     = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic          WrEn;
   logic [AW-1:0] WA;
   logic [N-1:0]  Din;
   logic [AW-1:0] RA;
   logic [AW-1:0] RB;
   logic          CLR;
   logic [N-1:0]  DoutA;
   logic [N-1:0]  DoutB;
   logic          BUSY;
   logic          WERR;
   logic          o_dbg_state;

   regfile_2r1w_sweep #(.N(N), .AW(AW), .RESET_VAL(8'h00)) dut (
      .CLK(CLK), .RST(RST), .WrEn(WrEn), .WA(WA), .Din(Din),
      .RA(RA), .RB(RB), .CLR(CLR),
      .DoutA(DoutA), .DoutB(DoutB), .BUSY(BUSY), .WERR(WERR),
      .o_dbg_state(o_dbg_state)
   );

   always #5 CLK = ~CLK;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   logic [N-1:0]  m_mem [DEPTH];
   bit            m_busy  = 1'b0;
   int            m_idx   = 0;
   logic [N-1:0]  exp_a;
   logic [N-1:0]  exp_b;
   logic          exp_busy;
   logic          exp_werr;
   int            busy_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s (cycle %0d): observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic drive(input bit rst, input bit we, input logic [AW-1:0] wa, input logic [N-1:0] d,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb, input bit clr);
      RST = rst; WrEn = we; WA = wa; Din = d; RA = ra; RB = rb; CLR = clr;
   endtask

   // Predict this edge's outcome from the current inputs, clock once, compare all outputs.
   task automatic step();
      if (RST) begin
         foreach (m_mem[i]) m_mem[i] = 8'h00;
         exp_a = '0; exp_b = '0; exp_werr = 1'b0; m_busy = 1'b0;
      end else begin
         exp_a = m_mem[RA];
         exp_b = m_mem[RB];
         exp_werr = 1'b0;
         if (!m_busy) begin
            if (CLR) begin
               exp_werr = WrEn;
               m_busy = 1'b1;
               m_idx = 0;
            end else if (WrEn) begin
`ifdef REGFILE_BYPASS_EN
               if (WA == RA) exp_a = Din;
               if (WA == RB) exp_b = Din;
`endif
               m_mem[WA] = Din;
            end
         end else begin
            exp_werr = WrEn;
            m_mem[AW'(m_idx)] = 8'h00;
            m_idx++;
            if (m_idx == DEPTH) m_busy = 1'b0;
         end
      end
      exp_busy = m_busy;
      @(posedge CLK);
      #1;
      cyc++;
      chk("douta", 32'(DoutA), 32'(exp_a));
      chk("doutb", 32'(DoutB), 32'(exp_b));
      chk("busy",  32'(BUSY),  32'(exp_busy));
      chk("werr",  32'(WERR),  32'(exp_werr));
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);
      #1;
      // Reset and read every address on both ports.
      step();
      chk("rst_state", 32'(o_dbg_state), 32'h0);
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, AW'(i), AW'(DEPTH - 1 - i), 0);
         step();
      end
      drive(0, 0, 0, 0, 7, 0, 0); step();
      chk("rst_read_a", 32'(DoutA), 32'h00);
      chk("rst_read_b", 32'(DoutB), 32'h00);

      // Basic writes then independent reads.
      drive(0, 1, 3, 8'hA5, 0, 0, 0); step();
      drive(0, 1, 6, 8'h5A, 0, 0, 0); step();
      drive(0, 0, 0, 0, 3, 6, 0); step();
      chk("rd_a_3", 32'(DoutA), 32'hA5);
      chk("rd_b_6", 32'(DoutB), 32'h5A);
      drive(0, 0, 0, 0, 6, 6, 0); step();
      chk("same_addr", 32'(DoutA), 32'(DoutB));

      // Same-edge read of the written address.
      drive(0, 1, 2, 8'h11, 0, 0, 0); step();
      drive(0, 1, 2, 8'h3C, 2, 2, 0); step();
`ifdef REGFILE_BYPASS_EN
      chk("same_edge_a", 32'(DoutA), 32'h3C);
`else
      chk("same_edge_a", 32'(DoutA), 32'h11);
`endif
      drive(0, 0, 0, 0, 2, 2, 0); step();
      chk("next_cycle_a", 32'(DoutA), 32'h3C);

      // Fill, sweep, dropped write at sweep cycle 4.
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 1, AW'(i), N'(8'h11 * (i + 1)), 0, 0, 0); step();
      end
      drive(0, 0, 0, 0, 0, 0, 1); step();
      busy_cnt = BUSY ? 1 : 0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k == 4) drive(0, 1, 6, 8'h77, 0, 0, 1);
         else        drive(0, 0, 0, 0, AW'(k), AW'(k), 1);
         step();
         if (k == 4) chk("werr_sweep", 32'(WERR), 32'h1);
         if (k == 5) chk("werr_one_cycle", 32'(WERR), 32'h0);
         if (BUSY) busy_cnt++;
      end
      chk("busy_len", 32'(busy_cnt), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, AW'(i), AW'(i), 0); step();
      end
      drive(0, 0, 0, 0, 6, 6, 0); step();
      chk("swept_6", 32'(DoutA), 32'h00);

      // CLR and WrEn together in IDLE.
      drive(0, 1, 1, 8'hFF, 0, 0, 1); step();
      chk("clr_wr_werr", 32'(WERR), 32'h1);
      chk("clr_busy", 32'(BUSY), 32'h1);
      for (int k = 0; k < DEPTH; k++) begin
         drive(0, 0, 0, 0, 1, 1, 0); step();
      end
      drive(0, 0, 0, 0, 1, 1, 0); step();
      chk("clr_wr_addr1", 32'(DoutA), 32'h00);

      // Reset in the middle of a sweep.
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 1, AW'(i), N'(8'hF0 | i), 0, 0, 0); step();
      end
      drive(0, 0, 0, 0, 0, 0, 1); step();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0); step();
      end
      drive(1, 0, 0, 0, 0, 0, 0); step();
      chk("rst_mid_busy", 32'(BUSY), 32'h0);
      drive(0, 1, 5, 8'h42, 7, 4, 0); step();
      chk("rst_mid_b4", 32'(DoutB), 32'h00);
      drive(0, 0, 0, 0, 5, 6, 0); step();
      chk("post_rst_wr5", 32'(DoutA), 32'h42);
      chk("post_rst_6", 32'(DoutB), 32'h00);

      // Randomized traffic.
      for (int t = 0; t < 400; t++) begin
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
               AW'($urandom_range(0, DEPTH - 1)), N'($urandom),
               AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
               $urandom_range(0, 24) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
